// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//
// Purpose:
//   Bundles every handshake and data signal of alu_arbiter: the two requester
//   ports, the shared ALU operand/opcode/result path and the shared response
//   register. Signal names are written from the arbiter's point of view, so
//   input_* is driven into the arbiter and output_* is driven by it.
//
// Modports:
//   slave  - used by alu_arbiter (receives requests and ALU results, drives
//            grants, ALU inputs and responses)
//   master - used by the environment (requesters plus the ALU)
//
// Signal summary:
//   input_Req{0,1}_Valid      request pending on port 0 / 1
//   output_Req{0,1}_Ready     request accepted this cycle (combinational)
//   input_Req{0,1}_Op         4-bit ALU opcode
//   input_Req{0,1}_A/_B       16-bit operands
//   output_ALU_A/_B/_Op       operands and opcode presented to the ALU
//   input_ALU_Result          ALU result
//   input_ALU_Zero/Negative/Carry  ALU flags
//   output_Resp{0,1}_Valid    response ready for port 0 / 1
//   input_Resp{0,1}_Ready     owner consumes the response
//   output_Resp_Data          registered result shared by both ports
//   output_Resp_Zero/Negative/Carry  registered flags
//   output_Resp_Error         the accepted opcode was illegal
//   output_Busy               arbiter is not idle
// -----------------------------------------------------------------------------
interface alu_arbiter_if;

    // Requester port 0
    logic        input_Req0_Valid;
    logic        output_Req0_Ready;
    logic [3:0]  input_Req0_Op;
    logic [15:0] input_Req0_A;
    logic [15:0] input_Req0_B;

    // Requester port 1
    logic        input_Req1_Valid;
    logic        output_Req1_Ready;
    logic [3:0]  input_Req1_Op;
    logic [15:0] input_Req1_A;
    logic [15:0] input_Req1_B;

    // Shared ALU
    logic [15:0] output_ALU_A;
    logic [15:0] output_ALU_B;
    logic [3:0]  output_ALU_Op;
    logic [15:0] input_ALU_Result;
    logic        input_ALU_Zero;
    logic        input_ALU_Negative;
    logic        input_ALU_Carry;

    // Responses
    logic        output_Resp0_Valid;
    logic        output_Resp1_Valid;
    logic        input_Resp0_Ready;
    logic        input_Resp1_Ready;
    logic [15:0] output_Resp_Data;
    logic        output_Resp_Zero;
    logic        output_Resp_Negative;
    logic        output_Resp_Carry;
    logic        output_Resp_Error;

    // Status
    logic        output_Busy;

    modport slave (
        input  input_Req0_Valid, input_Req0_Op, input_Req0_A, input_Req0_B,
        input  input_Req1_Valid, input_Req1_Op, input_Req1_A, input_Req1_B,
        output output_Req0_Ready, output_Req1_Ready,
        output output_ALU_A, output_ALU_B, output_ALU_Op,
        input  input_ALU_Result, input_ALU_Zero, input_ALU_Negative, input_ALU_Carry,
        output output_Resp0_Valid, output_Resp1_Valid,
        input  input_Resp0_Ready, input_Resp1_Ready,
        output output_Resp_Data, output_Resp_Zero, output_Resp_Negative,
        output output_Resp_Carry, output_Resp_Error,
        output output_Busy
    );

    modport master (
        output input_Req0_Valid, input_Req0_Op, input_Req0_A, input_Req0_B,
        output input_Req1_Valid, input_Req1_Op, input_Req1_A, input_Req1_B,
        input  output_Req0_Ready, output_Req1_Ready,
        input  output_ALU_A, output_ALU_B, output_ALU_Op,
        output input_ALU_Result, input_ALU_Zero, input_ALU_Negative, input_ALU_Carry,
        input  output_Resp0_Valid, output_Resp1_Valid,
        output input_Resp0_Ready, input_Resp1_Ready,
        input  output_Resp_Data, output_Resp_Zero, output_Resp_Negative,
        input  output_Resp_Carry, output_Resp_Error,
        input  output_Busy
    );

endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one ALU between two requesters (port 0: main datapath sequencer,
//   port 1: address/immediate unit). Requests are granted round-robin, the
//   winning operation is latched and held on the ALU for EXEC_CYCLES cycles,
//   and the result plus flags are returned in a response register that stays
//   put until the owning port consumes it.
//
// Parameters:
//   EXEC_CYCLES  cycles the ALU inputs are held before the result is sampled
//                (legal range 1..15)
//
// Ports:
//   input_CLK      system clock, all state on the rising edge
//   input_Reset_n  asynchronous, active-low reset
//   bus            alu_arbiter_if.slave - requests, ALU path, responses, busy
//
// Behaviour summary:
//   IDLE -> EXEC on a grant, EXEC -> RESP when the execute counter expires,
//   RESP -> IDLE when the owner's Resp_Ready is seen. Ready is only ever
//   asserted in IDLE, so there is always at least one IDLE cycle between
//   consecutive operations.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic          input_CLK,
    input  logic          input_Reset_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter reload: the first EXEC cycle already counts, so load N-1.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic        owner_q;        // port that owns the in-flight operation
    logic        ptr_q;          // port favoured when both request together
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  cnt_q;
    logic [15:0] data_q;
    logic        zero_q;
    logic        neg_q;
    logic        carry_q;
    logic        err_q;
    logic        resp0_valid_q;
    logic        resp1_valid_q;
    logic        busy_q;

    // -------------------------------------------------------------------------
    // Arbitration (combinational from Valid inputs and the pointer)
    // -------------------------------------------------------------------------
    logic        is_idle;
    logic        want0;
    logic        want1;
    logic        grant_any;
    logic        grant_port;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;

    assign is_idle = (state_q == IDLE);

    // A lone requester always wins; on a tie the pointer decides.
    assign want0 = bus.input_Req0_Valid && (!bus.input_Req1_Valid || !ptr_q);
    assign want1 = bus.input_Req1_Valid && (!bus.input_Req0_Valid ||  ptr_q);

    assign grant_any  = want0 || want1;
    assign grant_port = want1;

    assign req_op = grant_port ? bus.input_Req1_Op : bus.input_Req0_Op;
    assign req_a  = grant_port ? bus.input_Req1_A  : bus.input_Req0_A;
    assign req_b  = grant_port ? bus.input_Req1_B  : bus.input_Req0_B;

    // Gated by reset so every output reads 0 while reset is held, even though
    // Ready is otherwise a combinational function of the requesters.
    assign bus.output_Req0_Ready = input_Reset_n && is_idle && want0;
    assign bus.output_Req1_Ready = input_Reset_n && is_idle && want1;

    // -------------------------------------------------------------------------
    // Result capture values
    // -------------------------------------------------------------------------
    logic        op_legal;
    logic        carry_defined;
    logic [15:0] data_d;
    logic        zero_d;
    logic        neg_d;
    logic        carry_d;
    logic        owner_ready;

    // Legal opcodes: 0000..1000, 1100, 1101.
    assign op_legal      = (op_q <= 4'd8) || (op_q == 4'd12) || (op_q == 4'd13);
    // The ALU only defines carry for add (0000) and subtract (0001).
    assign carry_defined = (op_q == 4'd0) || (op_q == 4'd1);

    assign data_d  = op_legal ? bus.input_ALU_Result   : 16'h0000;
    assign zero_d  = op_legal && bus.input_ALU_Zero;
    assign neg_d   = op_legal && bus.input_ALU_Negative;
    assign carry_d = op_legal && carry_defined && bus.input_ALU_Carry;

    // Only the owner may release the response; the other port is ignored.
    assign owner_ready = owner_q ? bus.input_Resp1_Ready : bus.input_Resp0_Ready;

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            ptr_q         <= 1'b0;
            op_q          <= 4'h0;
            a_q           <= 16'h0000;
            b_q           <= 16'h0000;
            cnt_q         <= 4'h0;
            data_q        <= 16'h0000;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
            carry_q       <= 1'b0;
            err_q         <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        owner_q <= grant_port;
                        ptr_q   <= ~grant_port;
                        cnt_q   <= EXEC_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end

                EXEC: begin
                    if (cnt_q != 4'h0) begin
                        cnt_q <= cnt_q - 4'h1;
                    end else begin
                        data_q        <= data_d;
                        zero_q        <= zero_d;
                        neg_q         <= neg_d;
                        carry_q       <= carry_d;
                        err_q         <= !op_legal;
                        resp0_valid_q <= !owner_q;
                        resp1_valid_q <=  owner_q;
                        state_q       <= RESP;
                    end
                end

                RESP: begin
                    // Data/flag registers are left untouched here so they
                    // remain stable for the whole response phase.
                    if (owner_ready) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end

                default: begin
                    resp0_valid_q <= 1'b0;
                    resp1_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The ALU always sees the latches, including in IDLE, so its inputs never
    // follow requester lines that may still be settling.
    assign bus.output_ALU_A  = a_q;
    assign bus.output_ALU_B  = b_q;
    assign bus.output_ALU_Op = op_q;

    assign bus.output_Resp0_Valid   = resp0_valid_q;
    assign bus.output_Resp1_Valid   = resp1_valid_q;
    assign bus.output_Resp_Data     = data_q;
    assign bus.output_Resp_Zero     = zero_q;
    assign bus.output_Resp_Negative = neg_q;
    assign bus.output_Resp_Carry    = carry_q;
    assign bus.output_Resp_Error    = err_q;
    assign bus.output_Busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Two instances share one clock and reset:
// dut_a with EXEC_CYCLES=1 and dut_b with EXEC_CYCLES=4. A behavioural ALU
// model sits behind each instance. For undefined cases the model drives
// deliberately "dirty" values (carry=1 on non add/sub ops, DEAD and all
// flags set on illegal opcodes) so the arbiter's masking is visible.
// Cycle numbering: cycle 0 is the cycle in which Valid is first presented;
// all sampling happens 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arbiter_if ifa ();
    alu_arbiter_if ifb ();

    alu_arbiter #(.EXEC_CYCLES(1)) dut_a (
        .input_CLK     (clk),
        .input_Reset_n (rst_n),
        .bus           (ifa)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut_b (
        .input_CLK     (clk),
        .input_Reset_n (rst_n),
        .bus           (ifb)
    );

    // Behavioural ALU: returns {result, zero, negative, carry}.
    function automatic logic [18:0] alu_model(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        logic        ill;
        w   = 17'h0;
        r   = 16'h0;
        c   = 1'b1;
        ill = 1'b0;
        case (op)
            4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
            4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[3:0];
            4'd6:  r = a >> b[3:0];
            4'd7:  r = ~a;
            4'd8:  r = b;
            4'd12: r = a + 16'd1;
            4'd13: r = a - 16'd1;
            default: begin r = 16'hDEAD; ill = 1'b1; end
        endcase
        return {r, (r == 16'h0) | ill, r[15] | ill, c};
    endfunction

    assign {ifa.input_ALU_Result, ifa.input_ALU_Zero, ifa.input_ALU_Negative, ifa.input_ALU_Carry}
        = alu_model(ifa.output_ALU_Op, ifa.output_ALU_A, ifa.output_ALU_B);
    assign {ifb.input_ALU_Result, ifb.input_ALU_Zero, ifb.input_ALU_Negative, ifb.input_ALU_Carry}
        = alu_model(ifb.output_ALU_Op, ifb.output_ALU_A, ifb.output_ALU_B);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        ifa.input_Req0_Valid = 1'b0; ifa.input_Req0_Op = 4'h0; ifa.input_Req0_A = 16'h0; ifa.input_Req0_B = 16'h0;
        ifa.input_Req1_Valid = 1'b0; ifa.input_Req1_Op = 4'h0; ifa.input_Req1_A = 16'h0; ifa.input_Req1_B = 16'h0;
        ifa.input_Resp0_Ready = 1'b0; ifa.input_Resp1_Ready = 1'b0;
        ifb.input_Req0_Valid = 1'b0; ifb.input_Req0_Op = 4'h0; ifb.input_Req0_A = 16'h0; ifb.input_Req0_B = 16'h0;
        ifb.input_Req1_Valid = 1'b0; ifb.input_Req1_Op = 4'h0; ifb.input_Req1_A = 16'h0; ifb.input_Req1_B = 16'h0;
        ifb.input_Resp0_Ready = 1'b0; ifb.input_Resp1_Ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        tick();
        tick();
        checks++; if (ifa.output_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.output_Busy); end
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid}); end
        checks++; if (ifa.output_Resp_Data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", ifa.output_Resp_Data); end
        checks++; if ({ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error}); end
        checks++; if ({ifa.output_ALU_A, ifa.output_ALU_B, ifa.output_ALU_Op} !== 36'h0) begin errors++; $display("FAIL reset_alu_inputs: got %h want 0", {ifa.output_ALU_A, ifa.output_ALU_B, ifa.output_ALU_Op}); end
        checks++; if ({ifb.output_Busy, ifb.output_Req0_Ready, ifb.output_Req1_Ready} !== 3'b000) begin errors++; $display("FAIL reset_b_status: got %b want 000", {ifb.output_Busy, ifb.output_Req0_Ready, ifb.output_Req1_Ready}); end
        rst_n = 1'b1;
        tick();
        checks++; if (ifa.output_Busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", ifa.output_Busy); end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_single_add();
        ifa.input_Req0_Valid = 1'b1; ifa.input_Req0_Op = 4'd0; ifa.input_Req0_A = 16'hFFFF; ifa.input_Req0_B = 16'h0001;
        #1;
        checks++; if (ifa.output_Req0_Ready !== 1'b1) begin errors++; $display("FAIL add_ready0_c0: got %b want 1", ifa.output_Req0_Ready); end
        tick();
        ifa.input_Req0_Valid = 1'b0;
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Busy} !== 2'b01) begin errors++; $display("FAIL add_c1_state: got valid/busy %b want 01", {ifa.output_Resp0_Valid, ifa.output_Busy}); end
        checks++; if ({ifa.output_ALU_A, ifa.output_ALU_B} !== 32'hFFFF_0001) begin errors++; $display("FAIL add_alu_operands: got %h want ffff0001", {ifa.output_ALU_A, ifa.output_ALU_B}); end
        tick();
        $display("txn single_add: port0 op=0 data=%h z=%b n=%b c=%b err=%b", ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error);
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid} !== 2'b10) begin errors++; $display("FAIL add_resp_valid_c2: got %b want 10", {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid}); end
        checks++; if (ifa.output_Resp_Data !== 16'h0000) begin errors++; $display("FAIL add_data: got %h want 0000", ifa.output_Resp_Data); end
        checks++; if ({ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error} !== 4'b1010) begin errors++; $display("FAIL add_flags: got znce=%b want 1010", {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error}); end
        ifa.input_Resp0_Ready = 1'b1;
        tick();
        ifa.input_Resp0_Ready = 1'b0;
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Busy} !== 2'b00) begin errors++; $display("FAIL add_release: got valid/busy %b want 00", {ifa.output_Resp0_Valid, ifa.output_Busy}); end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_simultaneous();
        ifa.input_Resp0_Ready = 1'b1; ifa.input_Resp1_Ready = 1'b1;
        ifa.input_Req0_Valid = 1'b1; ifa.input_Req0_Op = 4'd1; ifa.input_Req0_A = 16'h0005; ifa.input_Req0_B = 16'h0007;
        ifa.input_Req1_Valid = 1'b1; ifa.input_Req1_Op = 4'd2; ifa.input_Req1_A = 16'h00F0; ifa.input_Req1_B = 16'h0F0F;
        #1;
        checks++; if ({ifa.output_Req0_Ready, ifa.output_Req1_Ready} !== 2'b10) begin errors++; $display("FAIL sim_first_grant: got r0r1=%b want 10", {ifa.output_Req0_Ready, ifa.output_Req1_Ready}); end
        tick();  // cycle 1, EXEC; port 0 keeps requesting
        checks++; if ({ifa.output_Req0_Ready, ifa.output_Req1_Ready} !== 2'b00) begin errors++; $display("FAIL sim_exec_ready: got r0r1=%b want 00", {ifa.output_Req0_Ready, ifa.output_Req1_Ready}); end
        tick();  // cycle 2, RESP port 0
        $display("txn sim_sub: port0 op=1 data=%h z=%b n=%b c=%b", ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry);
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid} !== 2'b10) begin errors++; $display("FAIL sim_resp0_valid: got %b want 10", {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid}); end
        checks++; if ({ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry} !== {16'hFFFE, 3'b011}) begin errors++; $display("FAIL sim_sub_result: got %h/%b want fffe/011", ifa.output_Resp_Data, {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry}); end
        tick();  // cycle 3, IDLE: both valid, pointer favours port 1
        checks++; if ({ifa.output_Req0_Ready, ifa.output_Req1_Ready} !== 2'b01) begin errors++; $display("FAIL sim_second_grant: got r0r1=%b want 01", {ifa.output_Req0_Ready, ifa.output_Req1_Ready}); end
        tick();  // cycle 4, EXEC port 1
        checks++; if (ifa.output_ALU_Op !== 4'd2) begin errors++; $display("FAIL sim_alu_op_port1: got %h want 2", ifa.output_ALU_Op); end
        tick();  // cycle 5, RESP port 1
        $display("txn sim_and: port1 op=2 data=%h z=%b n=%b c=%b", ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry);
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid} !== 2'b01) begin errors++; $display("FAIL sim_resp1_valid: got %b want 01", {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid}); end
        checks++; if ({ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry} !== {16'h0000, 3'b100}) begin errors++; $display("FAIL sim_and_result: got %h/%b want 0000/100", ifa.output_Resp_Data, {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry}); end
        tick();  // cycle 6, IDLE: both still valid, back to port 0
        checks++; if ({ifa.output_Req0_Ready, ifa.output_Req1_Ready} !== 2'b10) begin errors++; $display("FAIL sim_third_grant: got r0r1=%b want 10", {ifa.output_Req0_Ready, ifa.output_Req1_Ready}); end
        tick();
        ifa.input_Req0_Valid = 1'b0; ifa.input_Req1_Valid = 1'b0;
        tick();
        tick();
        checks++; if (ifa.output_Busy !== 1'b0) begin errors++; $display("FAIL sim_final_idle: got busy %b want 0", ifa.output_Busy); end
        ifa.input_Resp0_Ready = 1'b0; ifa.input_Resp1_Ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_illegal();
        ifa.input_Resp0_Ready = 1'b1; ifa.input_Resp1_Ready = 1'b1;
        ifa.input_Req1_Valid = 1'b1; ifa.input_Req1_Op = 4'b1010; ifa.input_Req1_A = 16'h1234; ifa.input_Req1_B = 16'h5678;
        #1;
        checks++; if (ifa.output_Req1_Ready !== 1'b1) begin errors++; $display("FAIL ill_ready1: got %b want 1", ifa.output_Req1_Ready); end
        tick();
        ifa.input_Req1_Valid = 1'b0;
        tick();
        $display("txn illegal: port1 op=a data=%h err=%b", ifa.output_Resp_Data, ifa.output_Resp_Error);
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid} !== 2'b01) begin errors++; $display("FAIL ill_resp_valid: got %b want 01", {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid}); end
        checks++; if ({ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error} !== {16'h0000, 4'b0001}) begin errors++; $display("FAIL ill_result: got %h/znce=%b want 0000/0001", ifa.output_Resp_Data, {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error}); end
        tick();
        ifa.input_Req1_Valid = 1'b1; ifa.input_Req1_Op = 4'd3; ifa.input_Req1_A = 16'h1200; ifa.input_Req1_B = 16'h0034;
        #1;
        tick();
        ifa.input_Req1_Valid = 1'b0;
        tick();
        $display("txn or_after_illegal: port1 op=3 data=%h err=%b", ifa.output_Resp_Data, ifa.output_Resp_Error);
        checks++; if ({ifa.output_Resp_Data, ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error} !== {16'h1234, 4'b0000}) begin errors++; $display("FAIL ill_next_legal: got %h/znce=%b want 1234/0000", ifa.output_Resp_Data, {ifa.output_Resp_Zero, ifa.output_Resp_Negative, ifa.output_Resp_Carry, ifa.output_Resp_Error}); end
        tick();
        ifa.input_Resp0_Ready = 1'b0; ifa.input_Resp1_Ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_backpressure();
        ifa.input_Req0_Valid = 1'b1; ifa.input_Req0_Op = 4'd4; ifa.input_Req0_A = 16'hFF00; ifa.input_Req0_B = 16'h0FF0;
        #1;
        checks++; if (ifa.output_Req0_Ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", ifa.output_Req0_Ready); end
        tick();
        ifa.input_Req0_Valid = 1'b0;
        ifa.input_Req1_Valid = 1'b1; ifa.input_Req1_Op = 4'd8; ifa.input_Req1_A = 16'h0000; ifa.input_Req1_B = 16'h0042;
        ifa.input_Resp1_Ready = 1'b1;  // non-owner ready must not release port 0's response
        #1;
        checks++; if (ifa.output_Req1_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready1_exec: got %b want 0", ifa.output_Req1_Ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp_Data, ifa.output_Resp_Negative, ifa.output_Req1_Ready} !== {1'b1, 16'hF0F0, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b data=%h n=%b r1=%b want 1 f0f0 1 0", i, ifa.output_Resp0_Valid, ifa.output_Resp_Data, ifa.output_Resp_Negative, ifa.output_Req1_Ready); end
            tick();
        end
        ifa.input_Resp0_Ready = 1'b1;
        #1;
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Req1_Ready} !== 2'b10) begin errors++; $display("FAIL bp_handshake_cycle: got valid/r1=%b want 10", {ifa.output_Resp0_Valid, ifa.output_Req1_Ready}); end
        $display("txn bp_xor: port0 op=4 data=%h n=%b", ifa.output_Resp_Data, ifa.output_Resp_Negative);
        tick();
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Req1_Ready} !== 2'b01) begin errors++; $display("FAIL bp_after_handshake: got valid/r1=%b want 01", {ifa.output_Resp0_Valid, ifa.output_Req1_Ready}); end
        tick();
        ifa.input_Resp0_Ready = 1'b0;
        ifa.input_Req1_Valid = 1'b0;
        tick();
        $display("txn bp_pass: port1 op=8 data=%h", ifa.output_Resp_Data);
        checks++; if ({ifa.output_Resp1_Valid, ifa.output_Resp_Data} !== {1'b1, 16'h0042}) begin errors++; $display("FAIL bp_port1_result: got valid=%b data=%h want 1 0042", ifa.output_Resp1_Valid, ifa.output_Resp_Data); end
        tick();
        ifa.input_Resp1_Ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_exec4();
        ifb.input_Resp0_Ready = 1'b1;
        ifb.input_Req0_Valid = 1'b1; ifb.input_Req0_Op = 4'd5; ifb.input_Req0_A = 16'h0001; ifb.input_Req0_B = 16'h000F;
        #1;
        checks++; if (ifb.output_Req0_Ready !== 1'b1) begin errors++; $display("FAIL e4_ready0: got %b want 1", ifb.output_Req0_Ready); end
        tick();
        // Change the now-released requester lines; the ALU must not follow.
        ifb.input_Req0_Valid = 1'b0; ifb.input_Req0_A = 16'hFFFF; ifb.input_Req0_Op = 4'd7;
        for (int c = 1; c <= 4; c++) begin
            checks++; if ({ifb.output_ALU_A, ifb.output_ALU_B, ifb.output_ALU_Op, ifb.output_Resp0_Valid} !== {16'h0001, 16'h000F, 4'd5, 1'b0}) begin errors++; $display("FAIL e4_hold_c%0d: got a=%h b=%h op=%h v=%b want 0001 000f 5 0", c, ifb.output_ALU_A, ifb.output_ALU_B, ifb.output_ALU_Op, ifb.output_Resp0_Valid); end
            tick();
        end
        $display("txn exec4_shl: port0 op=5 data=%h n=%b", ifb.output_Resp_Data, ifb.output_Resp_Negative);
        checks++; if (ifb.output_Resp0_Valid !== 1'b1) begin errors++; $display("FAIL e4_resp_valid_c5: got %b want 1", ifb.output_Resp0_Valid); end
        checks++; if ({ifb.output_Resp_Data, ifb.output_Resp_Zero, ifb.output_Resp_Negative, ifb.output_Resp_Carry} !== {16'h8000, 3'b010}) begin errors++; $display("FAIL e4_result: got %h/%b want 8000/010", ifb.output_Resp_Data, {ifb.output_Resp_Zero, ifb.output_Resp_Negative, ifb.output_Resp_Carry}); end
        tick();
        checks++; if (ifb.output_Busy !== 1'b0) begin errors++; $display("FAIL e4_idle: got busy %b want 0", ifb.output_Busy); end
        ifb.input_Resp0_Ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_during_exec();
        ifa.input_Resp0_Ready = 1'b1; ifa.input_Resp1_Ready = 1'b1;
        ifa.input_Req0_Valid = 1'b1; ifa.input_Req0_Op = 4'd0; ifa.input_Req0_A = 16'h0001; ifa.input_Req0_B = 16'h0001;
        #1;
        tick();  // accepted; pointer now favours port 1
        ifa.input_Req0_Valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({ifa.output_Busy, ifa.output_Resp0_Valid, ifa.output_ALU_A} !== 18'h0) begin errors++; $display("FAIL rexec_async: got busy=%b v=%b a=%h want 0 0 0000", ifa.output_Busy, ifa.output_Resp0_Valid, ifa.output_ALU_A); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp1_Valid, ifa.output_Busy} !== 3'b000) begin errors++; $display("FAIL rexec_no_resp_%0d: got v0v1busy=%b want 000", i, {ifa.output_Resp0_Valid, ifa.output_Resp1_Valid, ifa.output_Busy}); end
        end
        ifa.input_Req0_Valid = 1'b1; ifa.input_Req0_Op = 4'd0; ifa.input_Req0_A = 16'h0002; ifa.input_Req0_B = 16'h0003;
        ifa.input_Req1_Valid = 1'b1; ifa.input_Req1_Op = 4'd1; ifa.input_Req1_A = 16'h0009; ifa.input_Req1_B = 16'h0001;
        #1;
        checks++; if ({ifa.output_Req0_Ready, ifa.output_Req1_Ready} !== 2'b10) begin errors++; $display("FAIL rexec_ptr_port0: got r0r1=%b want 10", {ifa.output_Req0_Ready, ifa.output_Req1_Ready}); end
        tick();
        ifa.input_Req0_Valid = 1'b0; ifa.input_Req1_Valid = 1'b0;
        tick();
        $display("txn after_reset_add: port0 op=0 data=%h", ifa.output_Resp_Data);
        checks++; if ({ifa.output_Resp0_Valid, ifa.output_Resp_Data, ifa.output_Resp_Carry} !== {1'b1, 16'h0005, 1'b0}) begin errors++; $display("FAIL rexec_new_op: got v=%b data=%h c=%b want 1 0005 0", ifa.output_Resp0_Valid, ifa.output_Resp_Data, ifa.output_Resp_Carry); end
        tick();
        ifa.input_Resp0_Ready = 1'b0; ifa.input_Resp1_Ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        do_reset();
        test_simultaneous();
        test_illegal();
        test_backpressure();
        test_exec4();
        test_reset_during_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
